// File: rtl/flu_wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin onto registered scoreboard ports.
// Build option FLU_WB_ARB_PERF_EN adds a saturating stall counter output (stall_cnt_o).

module flu_wb_arbiter #(
  parameter int unsigned NR_CH       = 4,
  parameter int unsigned NR_WB_PORTS = 2,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TRANS_ID_W  = 3
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [NR_CH-1:0]                         ch_valid_i,
  output logic [NR_CH-1:0]                         ch_ready_o,
  input  logic [NR_CH-1:0][DATA_W-1:0]             ch_result_i,
  input  logic [NR_CH-1:0][TRANS_ID_W-1:0]         ch_trans_id_i,
  input  logic [NR_CH-1:0]                         ch_ex_valid_i,
  input  logic [NR_CH-1:0][63:0]                   ch_ex_cause_i,
  output logic [NR_WB_PORTS-1:0]                   wb_valid_o,
  output logic [NR_WB_PORTS-1:0][DATA_W-1:0]       wb_result_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_W-1:0]   wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0]                   wb_ex_valid_o,
  output logic [NR_WB_PORTS-1:0][63:0]             wb_ex_cause_o
`ifdef FLU_WB_ARB_PERF_EN
  , output logic [31:0]                            stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RR_W  = (NR_CH > 1) ? $clog2(NR_CH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  if (NR_WB_PORTS < 1 || NR_WB_PORTS > NR_CH) begin : g_bad_ports
    $error("flu_wb_arbiter: NR_WB_PORTS must be within 1..NR_CH");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("flu_wb_arbiter: FIFO_DEPTH must be at least 1");
  end

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [TRANS_ID_W-1:0] trans_id;
    logic                  ex_valid;
    logic [63:0]           ex_cause;
  } entry_t;

  entry_t                         mem_q [NR_CH][FIFO_DEPTH];
  entry_t [NR_CH-1:0]             ent_in;
  logic   [NR_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic   [NR_CH-1:0][PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic   [RR_W-1:0]              rr_q, rr_d;
  logic   [NR_CH-1:0]             nonempty, push, pop;
  logic   [NR_WB_PORTS-1:0]       gnt_vld;
  logic   [NR_WB_PORTS-1:0][RR_W-1:0] gnt_ch;
  logic   [NR_WB_PORTS-1:0]       wb_valid_q, wb_valid_d;
  entry_t [NR_WB_PORTS-1:0]       wb_q, wb_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered occupancy, so a full FIFO stays not-ready while draining.
  always_comb begin
    for (int unsigned i = 0; i < NR_CH; i++) begin
      nonempty[i]   = (cnt_q[i] != '0);
      ch_ready_o[i] = (cnt_q[i] < DEPTH_C);
      ent_in[i]     = '{result:   ch_result_i[i],
                        trans_id: ch_trans_id_i[i],
                        ex_valid: ch_ex_valid_i[i],
                        ex_cause: ch_ex_cause_i[i]};
    end
  end

  always_comb begin : arbitrate
    int unsigned n;
    int unsigned idx;
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    pop     = '0;
    gnt_vld = '0;
    gnt_ch  = '0;
    rr_d    = rr_q;
    n       = 0;
    for (int unsigned j = 0; j < NR_CH; j++) begin
      idx = 32'(rr_q) + j;
      if (idx >= NR_CH) idx -= NR_CH;
      if (nonempty[idx] && n < NR_WB_PORTS) begin
        pop[idx]   = 1'b1;
        gnt_vld[n] = 1'b1;
        gnt_ch[n]  = RR_W'(idx);
        rr_d       = (idx == NR_CH - 1) ? '0 : RR_W'(idx + 1);
        n++;
      end
    end
  end

  always_comb begin : fifo_next
    for (int unsigned i = 0; i < NR_CH; i++) begin
      push[i]     = ch_valid_i[i] & ch_ready_o[i] & ~flush_i;
      wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      wb_valid_d[k] = gnt_vld[k];
      wb_d[k]       = gnt_vld[k] ? mem_q[gnt_ch[k]][rd_ptr_q[gnt_ch[k]]] : '0;
    end
  end

  // NOTE: the payload array has no reset; the occupancy counters alone say which slots are live.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NR_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= ent_in[i];
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rr_q       <= '0;
      wb_valid_q <= '0;
      wb_q       <= '0;
    end else if (flush_i) begin
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rr_q       <= '0;
      wb_valid_q <= '0;
      wb_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  always_comb begin
    wb_valid_o = wb_valid_q;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      wb_result_o[k]   = wb_q[k].result;
      wb_trans_id_o[k] = wb_q[k].trans_id;
      wb_ex_valid_o[k] = wb_q[k].ex_valid;
      wb_ex_cause_o[k] = wb_q[k].ex_cause;
    end
  end

`ifdef FLU_WB_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  // A stall is a waiting head that lost arbitration, or a producer held off by a full FIFO.
  assign stall       = (|(nonempty & ~pop)) | (|(ch_valid_i & ~ch_ready_o));
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          stall_cnt_q <= '0;
    else if (flush_i)                     stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)  stall_cnt_q <= stall_cnt_q + 32'd1;
  end
`endif

endmodule
